// File: rtl/fpgaol_pkg.sv
// Board-wide timing constants shared by the switch conditioning logic.
// The default debounce window is derived from the system clock rate.
package fpgaol_pkg;

  localparam int CLK_HZ          = 100_000_000;
  localparam int DEBOUNCE_MS     = 10;
  localparam int DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;

endpackage

// File: rtl/debounce_bit.sv
// Single switch channel: synchroniser chain, stability counter and
// registered rise/fall strobes for the accepted clean level.
module debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = fpgaol_pkg::DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          count;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      count  <= '0;
      clean  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      // Plain shift chain: nothing taps the intermediate stages.
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (sync == clean) begin
        count <= '0;
      end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
        // Mismatch held for the full window: accept the new level.
        clean <= ~clean;
        count <= '0;
        rise  <= ~clean;
        fall  <= clean;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch conditioning: WIDTH independent synchronise-and-debounce
// channels producing clean levels and one-cycle edge strobes.
module sw_debounce #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = fpgaol_pkg::DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk   (clk),
      .rst   (rst),
      .sw    (sw[i]),
      .clean (sw_clean[i]),
      .rise  (sw_rise[i]),
      .fall  (sw_fall[i])
    );
  end

endmodule
